// File: rtl/lsu_mc_if.sv
// Controller and memory-side signal bundle for the load/store unit.
// master = environment (controller + memory), slave = lsu_mc.
interface lsu_mc_if #(
    parameter int N = 32
);
    logic           req;
    logic           we;
    logic [1:0]     size;
    logic           uns;
    logic [N-1:0]   addr;
    logic [N-1:0]   wdata;
    logic           busy;
    logic           done;
    logic           err;
    logic [N-1:0]   rdata;

    logic           mem_req;
    logic           mem_we;
    logic [N-1:0]   mem_adr;
    logic [N/8-1:0] mem_be;
    logic [N-1:0]   mem_wdata;
    logic           mem_ack;
    logic [N-1:0]   mem_rdata;

    modport master (
        output req, we, size, uns, addr, wdata, mem_ack, mem_rdata,
        input  busy, done, err, rdata, mem_req, mem_we, mem_adr, mem_be, mem_wdata
    );

    modport slave (
        input  req, we, size, uns, addr, wdata, mem_ack, mem_rdata,
        output busy, done, err, rdata, mem_req, mem_we, mem_adr, mem_be, mem_wdata
    );
endinterface

// File: rtl/lsu_mc.sv
// Single-access big-endian load/store unit: alignment check, lane steering,
// load extension and a bounded wait for the memory acknowledge.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting for req; captures and checks the request
//   ACCESS | mem_req held high, counting cycles until mem_ack or timeout
//   DONE   | one-cycle done pulse, then back to IDLE
//   ERR    | one-cycle err pulse (misaligned or timed out), then IDLE
module lsu_mc #(
    parameter int N       = 32,
    parameter int TIMEOUT = 16
) (
    input logic   clk,
    input logic   reset,
    lsu_mc_if.slave bus
);

    localparam int NB = N / 8;
    localparam int AW = $clog2(NB);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE,
        ERR
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            we_q;
    logic            uns_q;
    logic [1:0]      size_q;
    logic [AW-1:0]   off_q;

    function automatic logic is_aligned(input logic [1:0] sz, input logic [2:0] a);
        logic ok;
        case (sz)
            2'd0:    ok = 1'b1;
            2'd1:    ok = ~a[0];
            2'd2:    ok = (a[1:0] == 2'b00);
            default: ok = (N == 64) && (a == 3'b000);
        endcase
        return ok;
    endfunction

    // Number of bytes in the access, clamped so illegal sizes cannot overrun the word.
    function automatic int access_bytes(input logic [1:0] sz);
        int b;
        b = 1 << sz;
        if (b > NB) b = NB;
        return b;
    endfunction

    // Lowest lane touched: offset k occupies lane NB-1-k, so the access spans
    // lanes [NB-1-k : NB-k-bytes].
    function automatic int low_lane(input logic [1:0] sz, input logic [AW-1:0] off);
        int lo;
        lo = NB - int'(off) - access_bytes(sz);
        if (lo < 0) lo = 0;
        return lo;
    endfunction

    function automatic logic [NB-1:0] lane_mask(input logic [1:0] sz, input logic [AW-1:0] off);
        logic [NB-1:0] m;
        m = ~({NB{1'b1}} << access_bytes(sz));
        m = m << low_lane(sz, off);
        return m;
    endfunction

    function automatic logic [N-1:0] replicate(input logic [1:0] sz, input logic [N-1:0] w);
        logic [N-1:0] r;
        case (sz)
            2'd0:    r = {NB{w[7:0]}};
            2'd1:    r = {(NB / 2){w[15:0]}};
            2'd2:    r = {(N / 32){w[31:0]}};
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [N-1:0] extract(input logic [1:0] sz, input logic u,
                                             input logic [AW-1:0] off, input logic [N-1:0] w);
        logic [N-1:0] sh;
        logic [N-1:0] keep;
        logic [N-1:0] top;
        logic         sgn;
        int           nbits;
        nbits = 8 * access_bytes(sz);
        sh    = w >> (8 * low_lane(sz, off));
        keep  = ~({N{1'b1}} << nbits);
        top   = sh >> (nbits - 1);
        sgn   = ~u & top[0];
        return (sh & keep) | ({N{sgn}} & ~keep);
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            cnt           <= '0;
            we_q          <= 1'b0;
            uns_q         <= 1'b0;
            size_q        <= '0;
            off_q         <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
            bus.rdata     <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_adr   <= '0;
            bus.mem_be    <= '0;
            bus.mem_wdata <= '0;
        end else begin
            bus.done <= 1'b0;
            bus.err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        we_q     <= bus.we;
                        uns_q    <= bus.uns;
                        size_q   <= bus.size;
                        off_q    <= bus.addr[AW-1:0];
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        if (is_aligned(bus.size, bus.addr[2:0])) begin
                            state         <= ACCESS;
                            bus.mem_req   <= 1'b1;
                            bus.mem_we    <= bus.we;
                            bus.mem_adr   <= {bus.addr[N-1:AW], {AW{1'b0}}};
                            bus.mem_be    <= lane_mask(bus.size, bus.addr[AW-1:0]);
                            bus.mem_wdata <= replicate(bus.size, bus.wdata);
                        end else begin
                            state   <= ERR;
                            bus.err <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    // An ack in the last permitted cycle still completes normally.
                    if (bus.mem_ack) begin
                        state       <= DONE;
                        bus.done    <= 1'b1;
                        bus.mem_req <= 1'b0;
                        bus.mem_we  <= 1'b0;
                        bus.mem_be  <= '0;
                        if (!we_q) bus.rdata <= extract(size_q, uns_q, off_q, bus.mem_rdata);
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        state       <= ERR;
                        bus.err     <= 1'b1;
                        bus.mem_req <= 1'b0;
                        bus.mem_we  <= 1'b0;
                        bus.mem_be  <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE, ERR: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mc.sv
// Directed and random bench for lsu_mc (N=32, TIMEOUT=8) against a byte-level
// big-endian reference model.
module tb_lsu_mc;

   localparam int N  = 32;
   localparam int TO = 8;

   logic        clk;
   logic        reset;
   int          checks;
   int          errors;
   logic [31:0] exp_rdata;

   lsu_mc_if #(.N(N)) bus ();

   lsu_mc #(.N(N), .TIMEOUT(TO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input bit pass, input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      if (!pass) begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Byte at address offset off within a big-endian word.
   function automatic logic [7:0] byte_at(input logic [31:0] w, input int off);
      logic [31:0] s;
      s = w >> (8 * (3 - off));
      return s[7:0];
   endfunction

   function automatic bit ref_aligned(input logic [1:0] sz, input logic [31:0] a);
      int n;
      n = 1 << sz;
      return (sz <= 2'd2) && ((int'(a[2:0]) % n) == 0);
   endfunction

   function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic u,
                                            input logic [31:0] a, input logic [31:0] w);
      int          n;
      int          k;
      logic [63:0] v;
      logic [63:0] msb;
      n = 1 << sz;
      k = int'(a[1:0]);
      v = 64'd0;
      for (int j = 0; j < n; j++) v = (v << 8) | {56'd0, byte_at(w, k + j)};
      msb = v >> (8 * n - 1);
      if (!u && n < 4 && msb[0]) v = v | (~64'd0 << (8 * n));
      return v[31:0];
   endfunction

   function automatic logic [3:0] ref_be(input logic [1:0] sz, input logic [31:0] a);
      int         n;
      int         k;
      logic [3:0] be;
      n  = 1 << sz;
      k  = int'(a[1:0]);
      be = 4'd0;
      for (int j = 0; j < n; j++) be = be | 4'(1 << (3 - (k + j)));
      return be;
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] wd);
      int          n;
      logic [63:0] d;
      logic [63:0] rep;
      n   = 1 << sz;
      d   = {32'd0, wd} & ((64'd1 << (8 * n)) - 64'd1);
      rep = 64'd0;
      for (int j = 0; j < 4 / n; j++) rep = (rep << (8 * n)) | d;
      return rep[31:0];
   endfunction

   // One complete request. ack_at = ACCESS cycle index that gets mem_ack (<0 or >=TO: never).
   // poke drives req and mem_ack during the DONE/ERR cycle, both of which must be ignored.
   task automatic run(input string tag, input logic st, input logic [1:0] sz, input logic u,
                      input logic [31:0] a, input logic [31:0] wd, input int ack_at,
                      input logic [31:0] mword, input bit poke);
      bit ok;
      bit acked;
      int n;
      int exp_n;
      logic [3:0]  e_be;
      logic [31:0] e_wd;
      ok = ref_aligned(sz, a);
      bus.req   = 1'b1;
      bus.we    = st;
      bus.size  = sz;
      bus.uns   = u;
      bus.addr  = a;
      bus.wdata = wd;
      @(posedge clk); #1;
      bus.req   = 1'b0;
      bus.we    = 1'($urandom);
      bus.size  = 2'($urandom);
      bus.uns   = 1'($urandom);
      bus.addr  = $urandom;
      bus.wdata = $urandom;
      check({tag, ":busy_c1"}, bus.busy === 1'b1, bus.busy, 1'b1);
      if (!ok) begin
         check({tag, ":err_c1"}, bus.err === 1'b1, bus.err, 1'b1);
         check({tag, ":done_c1"}, bus.done === 1'b0, bus.done, 1'b0);
         check({tag, ":mem_req_c1"}, bus.mem_req === 1'b0, bus.mem_req, 1'b0);
      end else begin
         check({tag, ":err_c1"}, bus.err === 1'b0, bus.err, 1'b0);
         check({tag, ":done_c1"}, bus.done === 1'b0, bus.done, 1'b0);
         e_be = ref_be(sz, a);
         e_wd = ref_wdata(sz, wd);
         n = 0;
         while (bus.mem_req === 1'b1 && n < TO + 2) begin
            if (n == 0) begin
               check({tag, ":mem_adr"}, bus.mem_adr === (a & 32'hFFFF_FFFC), bus.mem_adr,
                     a & 32'hFFFF_FFFC);
               check({tag, ":mem_be"}, bus.mem_be === e_be, bus.mem_be, e_be);
               check({tag, ":mem_we"}, bus.mem_we === st, bus.mem_we, st);
               if (st) check({tag, ":mem_wdata"}, bus.mem_wdata === e_wd, bus.mem_wdata, e_wd);
            end
            bus.mem_ack   = (n == ack_at);
            bus.mem_rdata = (n == ack_at) ? mword : $urandom;
            @(posedge clk); #1;
            bus.mem_ack = 1'b0;
            n++;
         end
         acked = (ack_at >= 0) && (ack_at < TO);
         exp_n = acked ? ack_at + 1 : TO;
         if (acked && !st) exp_rdata = ref_load(sz, u, a, mword);
         check({tag, ":mem_req_cycles"}, n === exp_n, n, exp_n);
         check({tag, ":done"}, bus.done === acked, bus.done, acked);
         check({tag, ":err"}, bus.err === !acked, bus.err, !acked);
         check({tag, ":busy_end"}, bus.busy === 1'b1, bus.busy, 1'b1);
         check({tag, ":mem_we_off"}, bus.mem_we === 1'b0, bus.mem_we, 1'b0);
         check({tag, ":mem_be_off"}, bus.mem_be === 4'b0000, bus.mem_be, 4'b0000);
      end
      check({tag, ":rdata"}, bus.rdata === exp_rdata, bus.rdata, exp_rdata);
      if (poke) begin
         bus.req       = 1'b1;
         bus.we        = 1'b0;
         bus.size      = 2'd2;
         bus.addr      = 32'h0;
         bus.mem_ack   = 1'b1;
         bus.mem_rdata = 32'hCAFE_0001;
      end
      @(posedge clk); #1;
      bus.req     = 1'b0;
      bus.mem_ack = 1'b0;
      check({tag, ":busy_idle"}, bus.busy === 1'b0, bus.busy, 1'b0);
      check({tag, ":done_idle"}, bus.done === 1'b0, bus.done, 1'b0);
      check({tag, ":err_idle"}, bus.err === 1'b0, bus.err, 1'b0);
      check({tag, ":mem_req_idle"}, bus.mem_req === 1'b0, bus.mem_req, 1'b0);
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      exp_rdata     = 32'h0;
      reset         = 1'b0;
      bus.req       = 1'b0;
      bus.we        = 1'b0;
      bus.size      = 2'd0;
      bus.uns       = 1'b0;
      bus.addr      = 32'h0;
      bus.wdata     = 32'h0;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 32'h0;

      repeat (3) @(posedge clk);
      #1;
      check("rst:busy", bus.busy === 1'b0, bus.busy, 1'b0);
      check("rst:done", bus.done === 1'b0, bus.done, 1'b0);
      check("rst:err", bus.err === 1'b0, bus.err, 1'b0);
      check("rst:rdata", bus.rdata === 32'h0, bus.rdata, 32'h0);
      check("rst:mem_req", bus.mem_req === 1'b0, bus.mem_req, 1'b0);
      check("rst:mem_we", bus.mem_we === 1'b0, bus.mem_we, 1'b0);
      check("rst:mem_be", bus.mem_be === 4'b0000, bus.mem_be, 4'b0000);
      reset = 1'b1;
      @(posedge clk); #1;

      run("lb", 1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 0, 32'h1234_56F0, 1'b0);
      check("lb:value", bus.rdata === 32'hFFFF_FFF0, bus.rdata, 32'hFFFF_FFF0);
      run("lbu", 1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 0, 32'h1234_56F0, 1'b0);
      check("lbu:value", bus.rdata === 32'h0000_00F0, bus.rdata, 32'h0000_00F0);
      run("sh", 1'b1, 2'd1, 1'b0, 32'h202, 32'h0000_ABCD, 0, 32'h5555_5555, 1'b0);
      check("sh:rdata_kept", bus.rdata === 32'h0000_00F0, bus.rdata, 32'h0000_00F0);
      run("lw_mis", 1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 0, 32'h0, 1'b0);
      run("sz3", 1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 0, 32'h0, 1'b0);
      run("timeout", 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, -1, 32'h0, 1'b0);
      run("ack_last", 1'b0, 2'd2, 1'b0, 32'h44, 32'h0, TO - 1, 32'h0BAD_F00D, 1'b0);
      check("ack_last:value", bus.rdata === 32'h0BAD_F00D, bus.rdata, 32'h0BAD_F00D);

      // Reset in the third ACCESS cycle, with req and mem_ack also high.
      bus.req  = 1'b1;
      bus.we   = 1'b0;
      bus.size = 2'd2;
      bus.addr = 32'h80;
      @(posedge clk); #1;
      bus.req = 1'b0;
      repeat (2) begin
         check("rst_mid:mem_req_pre", bus.mem_req === 1'b1, bus.mem_req, 1'b1);
         @(posedge clk); #1;
      end
      check("rst_mid:mem_req_c3", bus.mem_req === 1'b1, bus.mem_req, 1'b1);
      reset         = 1'b0;
      bus.req       = 1'b1;
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'h7777_7777;
      @(posedge clk); #1;
      reset       = 1'b1;
      bus.req     = 1'b0;
      bus.mem_ack = 1'b0;
      exp_rdata   = 32'h0;
      check("rst_mid:mem_req", bus.mem_req === 1'b0, bus.mem_req, 1'b0);
      check("rst_mid:busy", bus.busy === 1'b0, bus.busy, 1'b0);
      check("rst_mid:rdata", bus.rdata === 32'h0, bus.rdata, 32'h0);
      check("rst_mid:done", bus.done === 1'b0, bus.done, 1'b0);
      check("rst_mid:err", bus.err === 1'b0, bus.err, 1'b0);
      run("lw_after_rst", 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 0, 32'hDEAD_BEEF, 1'b0);
      check("lw_after_rst:value", bus.rdata === 32'hDEAD_BEEF, bus.rdata, 32'hDEAD_BEEF);

      // req in the DONE cycle and mem_ack while IDLE are both ignored.
      run("poke", 1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 0, 32'h1122_3344, 1'b1);
      bus.mem_ack = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
         check("idle_ack:mem_req", bus.mem_req === 1'b0, bus.mem_req, 1'b0);
         check("idle_ack:done", bus.done === 1'b0, bus.done, 1'b0);
         check("idle_ack:busy", bus.busy === 1'b0, bus.busy, 1'b0);
      end
      bus.mem_ack = 1'b0;
      check("idle_ack:rdata", bus.rdata === 32'h0000_3344, bus.rdata, 32'h0000_3344);

      for (int i = 0; i < 40; i++) begin
         logic [31:0] a;
         logic [1:0]  sz;
         a  = $urandom;
         sz = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
         run("rnd", 1'($urandom), sz, 1'($urandom), a, $urandom,
             int'($urandom_range(0, 9)), $urandom, 1'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
